// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Central hold/flush sequencer for the 5-stage RV32IM pipeline. It looks at
//   load-use hazards, taken branches/jumps, multi-cycle MUL/DIV occupancy of
//   EX, and instruction/data memory busywait. From these it drives the hold
//   (keep value) and flush (load bubble) inputs of the PC and of the IF/ID,
//   ID/EX, EX/MEM and MEM/WB registers.
//
// Ports
//   CLK, RESET                   clock (rising edge), synchronous active-high reset
//   ID_RS1/ID_RS2, ID_USES_RS*   source registers of the instruction in ID
//   EX_RD, EX_MEM_READ           destination / load flag of the instruction in EX
//   EX_MULDIV                    instruction in EX is an M-extension op
//   BRANCH_TAKEN                 EX resolved a taken branch or jump
//   IMEM_BUSYWAIT, DMEM_BUSYWAIT memory not-ready indications
//   PC_HOLD, *_HOLD              register keeps its value at the next edge
//   *_FLUSH                      register loads a bubble at the next edge
//   MULDIV_BUSY                  sequencer is in the MUL/DIV occupancy state
//   STALL_COUNT                  number of cycles in which PC_HOLD was asserted
module pipeline_hazard_controller #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic        ID_USES_RS1,
  input  logic        ID_USES_RS2,
  input  logic [4:0]  EX_RD,
  input  logic        EX_MEM_READ,
  input  logic        EX_MULDIV,
  input  logic        BRANCH_TAKEN,
  input  logic        IMEM_BUSYWAIT,
  input  logic        DMEM_BUSYWAIT,
  output logic        PC_HOLD,
  output logic        IF_ID_HOLD,
  output logic        ID_EX_HOLD,
  output logic        EX_MEM_HOLD,
  output logic        MEM_WB_HOLD,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_FLUSH,
  output logic        EX_MEM_FLUSH,
  output logic        MULDIV_BUSY,
  output logic [31:0] STALL_COUNT
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    MULDIV = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       stall_count_q, stall_count_d;
  logic              load_use;

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = EX_MEM_READ && (EX_RD != 5'd0) &&
                    ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                     (ID_USES_RS2 && (ID_RS2 == EX_RD)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    PC_HOLD      = 1'b0;
    IF_ID_HOLD   = 1'b0;
    ID_EX_HOLD   = 1'b0;
    EX_MEM_HOLD  = 1'b0;
    MEM_WB_HOLD  = 1'b0;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    EX_MEM_FLUSH = 1'b0;

    if (RESET) begin
      // Fill the pipeline with bubbles while reset is held.
      IF_ID_FLUSH  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
      EX_MEM_FLUSH = 1'b1;
    end else if (DMEM_BUSYWAIT) begin
      // Whole pipeline freezes, including the MUL/DIV countdown.
      PC_HOLD     = 1'b1;
      IF_ID_HOLD  = 1'b1;
      ID_EX_HOLD  = 1'b1;
      EX_MEM_HOLD = 1'b1;
      MEM_WB_HOLD = 1'b1;
    end else if (state_q == MULDIV) begin
      if (cnt_q != '0) begin
        PC_HOLD      = 1'b1;
        IF_ID_HOLD   = 1'b1;
        ID_EX_HOLD   = 1'b1;
        EX_MEM_FLUSH = 1'b1;
        cnt_d        = cnt_q - CNT_W'(1);
      end else begin
        // Release cycle: the result leaves EX; EX_MULDIV is deliberately
        // ignored here so the same instruction cannot retrigger.
        state_d = RUN;
      end
    end else if (EX_MULDIV) begin
      // The start cycle is the first of MULDIV_CYCLES, and the release
      // cycle is the last, hence the -2 preload.
      PC_HOLD      = 1'b1;
      IF_ID_HOLD   = 1'b1;
      ID_EX_HOLD   = 1'b1;
      EX_MEM_FLUSH = 1'b1;
      state_d      = MULDIV;
      cnt_d        = CNT_W'(MULDIV_CYCLES - 2);
    end else if (BRANCH_TAKEN) begin
      // PC stays free so the branch target loads.
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end else if (load_use) begin
      // One bubble; forwarding resolves the hazard afterwards. IF/ID holds
      // (not flushes) even if IMEM is also busy, to keep the dependent op.
      PC_HOLD     = 1'b1;
      IF_ID_HOLD  = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end else if (IMEM_BUSYWAIT) begin
      PC_HOLD     = 1'b1;
      IF_ID_FLUSH = 1'b1;
    end
  end

  assign stall_count_d = stall_count_q + {31'd0, PC_HOLD};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      stall_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign MULDIV_BUSY = (state_q == MULDIV);
  assign STALL_COUNT = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed testbench for pipeline_hazard_controller with MULDIV_CYCLES=4.
// Control outputs are packed as
//   {PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD,
//    IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MULDIV_BUSY}
module tb_pipeline_hazard_controller;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  ID_RS1, ID_RS2, EX_RD;
  logic        ID_USES_RS1, ID_USES_RS2, EX_MEM_READ, EX_MULDIV;
  logic        BRANCH_TAKEN, IMEM_BUSYWAIT, DMEM_BUSYWAIT;
  logic        PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD;
  logic        IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MULDIV_BUSY;
  logic [31:0] STALL_COUNT;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_controller #(.MULDIV_CYCLES(4), .CNT_W(6)) dut (
    .CLK(CLK), .RESET(RESET),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ), .EX_MULDIV(EX_MULDIV),
    .BRANCH_TAKEN(BRANCH_TAKEN),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
    .PC_HOLD(PC_HOLD), .IF_ID_HOLD(IF_ID_HOLD), .ID_EX_HOLD(ID_EX_HOLD),
    .EX_MEM_HOLD(EX_MEM_HOLD), .MEM_WB_HOLD(MEM_WB_HOLD),
    .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH),
    .EX_MEM_FLUSH(EX_MEM_FLUSH), .MULDIV_BUSY(MULDIV_BUSY),
    .STALL_COUNT(STALL_COUNT)
  );

  always #5 CLK = ~CLK;

  localparam logic [8:0] C_IDLE   = 9'b00000_000_0;
  localparam logic [8:0] C_RESET  = 9'b00000_111_0;
  localparam logic [8:0] C_LDUSE  = 9'b11000_010_0;
  localparam logic [8:0] C_IMEM   = 9'b10000_100_0;
  localparam logic [8:0] C_BRANCH = 9'b00000_110_0;
  localparam logic [8:0] C_MDSTRT = 9'b11100_001_0;
  localparam logic [8:0] C_MDHOLD = 9'b11100_001_1;
  localparam logic [8:0] C_MDREL  = 9'b00000_000_1;
  localparam logic [8:0] C_DMEM   = 9'b11111_000_0;
  localparam logic [8:0] C_DMEMMD = 9'b11111_000_1;

  function automatic logic [8:0] ctl();
    return {PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD,
            IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MULDIV_BUSY};
  endfunction

  task automatic chk_ctl(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = ctl();
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s ctl obs=%b exp=%b", tag, obs, exp);
      end
    $display("step %s ctl=%b exp=%b", tag, obs, exp);
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    total++;
    assert (STALL_COUNT === exp)
      else begin
        bad++;
        $error("FAIL %s stall_count obs=%0d exp=%0d", tag, STALL_COUNT, exp);
      end
    $display("step %s stall_count=%0d exp=%0d", tag, STALL_COUNT, exp);
  endtask

  task automatic idle_inputs();
    ID_RS1 = 5'd0; ID_RS2 = 5'd0; ID_USES_RS1 = 1'b0; ID_USES_RS2 = 1'b0;
    EX_RD = 5'd0; EX_MEM_READ = 1'b0; EX_MULDIV = 1'b0;
    BRANCH_TAKEN = 1'b0; IMEM_BUSYWAIT = 1'b0; DMEM_BUSYWAIT = 1'b0;
  endtask

  initial begin
    idle_inputs();
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk_ctl("reset_ctl", C_RESET);
    chk_cnt("reset_cnt", 32'd0);
    @(negedge CLK);

    // Idle run
    RESET = 1'b0;
    #1 chk_ctl("idle", C_IDLE);
    @(negedge CLK);

    // Load-use on rs1: lw x5 in EX, add x6,x5,x1 in ID
    EX_MEM_READ = 1'b1; EX_RD = 5'd5;
    ID_RS1 = 5'd5; ID_USES_RS1 = 1'b1; ID_RS2 = 5'd1; ID_USES_RS2 = 1'b1;
    #1 chk_ctl("lduse_rs1", C_LDUSE);
    @(negedge CLK);
    // Bubble now in EX: hazard gone
    EX_MEM_READ = 1'b0; EX_RD = 5'd0;
    #1 chk_ctl("lduse_after", C_IDLE);
    chk_cnt("lduse_cnt", 32'd1);
    @(negedge CLK);

    // Load-use on rs2 only
    EX_MEM_READ = 1'b1; EX_RD = 5'd7;
    ID_RS1 = 5'd7; ID_USES_RS1 = 1'b0; ID_RS2 = 5'd7; ID_USES_RS2 = 1'b1;
    #1 chk_ctl("lduse_rs2", C_LDUSE);
    @(negedge CLK);
    // rs1 matches but is not used, rs2 differs
    ID_RS2 = 5'd3;
    #1 chk_ctl("lduse_unused", C_IDLE);
    @(negedge CLK);
    // Load into x0 never stalls
    EX_RD = 5'd0; ID_RS1 = 5'd0; ID_USES_RS1 = 1'b1; ID_RS2 = 5'd0;
    #1 chk_ctl("lduse_x0", C_IDLE);
    chk_cnt("x0_cnt", 32'd2);
    @(negedge CLK);

    // IMEM busywait alone
    idle_inputs();
    IMEM_BUSYWAIT = 1'b1;
    #1 chk_ctl("imem", C_IMEM);
    @(negedge CLK);
    // Load-use beats IMEM busywait
    EX_MEM_READ = 1'b1; EX_RD = 5'd9; ID_RS1 = 5'd9; ID_USES_RS1 = 1'b1;
    #1 chk_ctl("lduse_imem", C_LDUSE);
    @(negedge CLK);
    // Branch beats both
    BRANCH_TAKEN = 1'b1;
    #1 chk_ctl("branch_all", C_BRANCH);
    @(negedge CLK);
    idle_inputs();
    #1 chk_cnt("branch_cnt", 32'd4);

    // MUL/DIV: 3 hold cycles then release
    EX_MULDIV = 1'b1;
    #1 chk_ctl("md_start", C_MDSTRT);
    @(negedge CLK);
    #1 chk_ctl("md_cnt2", C_MDHOLD);
    @(negedge CLK);
    BRANCH_TAKEN = 1'b1;
    #1 chk_ctl("md_cnt1_br", C_MDHOLD);
    @(negedge CLK);
    BRANCH_TAKEN = 1'b0;
    #1 chk_ctl("md_release", C_MDREL);
    @(negedge CLK);
    EX_MULDIV = 1'b0;
    #1 chk_ctl("md_done", C_IDLE);
    chk_cnt("md_cnt", 32'd7);

    // DMEM busywait for 5 cycles at CNT=1
    EX_MULDIV = 1'b1;
    #1 chk_ctl("mdd_start", C_MDSTRT);
    @(negedge CLK);
    #1 chk_ctl("mdd_cnt2", C_MDHOLD);
    @(negedge CLK);
    DMEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk_ctl($sformatf("mdd_dmem%0d", i), C_DMEMMD);
      @(negedge CLK);
    end
    DMEM_BUSYWAIT = 1'b0;
    #1 chk_ctl("mdd_cnt1", C_MDHOLD);
    @(negedge CLK);
    #1 chk_ctl("mdd_release", C_MDREL);
    @(negedge CLK);
    EX_MULDIV = 1'b0;
    #1 chk_ctl("mdd_done", C_IDLE);
    chk_cnt("mdd_cnt", 32'd15);

    // DMEM busywait in RUN beats branch
    DMEM_BUSYWAIT = 1'b1; BRANCH_TAKEN = 1'b1;
    #1 chk_ctl("dmem_branch", C_DMEM);
    @(negedge CLK);
    idle_inputs();

    // Reset while in MULDIV aborts the operation
    EX_MULDIV = 1'b1;
    #1 chk_ctl("rst_md_start", C_MDSTRT);
    @(negedge CLK);
    RESET = 1'b1;
    #1 chk_ctl("rst_in_md", 9'b00000_111_1);
    @(negedge CLK);
    #1 chk_ctl("rst_md_2", C_RESET);
    chk_cnt("rst_md_cnt", 32'd0);
    @(negedge CLK);
    RESET = 1'b0; EX_MULDIV = 1'b0;
    #1 chk_ctl("rst_md_run", C_IDLE);
    @(negedge CLK);

    // STALL_COUNT wrap: preload all-ones, then one stall cycle
    force dut.stall_count_q = 32'hFFFF_FFFF;
    @(posedge CLK);
    #1 release dut.stall_count_q;
    @(negedge CLK);
    #1 chk_cnt("wrap_preload", 32'hFFFF_FFFF);
    IMEM_BUSYWAIT = 1'b1;
    #1 chk_ctl("wrap_stall", C_IMEM);
    @(negedge CLK);
    IMEM_BUSYWAIT = 1'b0;
    #1 chk_cnt("wrap_zero", 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencer for the RV32IM 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-stage HOLD and FLUSH controls from four conditions: load-use hazards, taken branches and jumps, multi-cycle MUL/DIV occupancy of EX, and instruction/data memory busywait.
- Sits beside the decode stage.
- Drives the BUSYWAIT-style hold inputs and bubble-insert inputs of every pipeline register.

Parameters:
- MULDIV_CYCLES, 32, total cycles a MUL/DIV instruction occupies EX; must be at least 2.
- CNT_W, 6, width of the MUL/DIV down-counter; must satisfy 2^CNT_W > MULDIV_CYCLES.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- ID_RS1  in  5  rs1 of the instruction in ID.
- ID_RS2  in  5  rs2 of the instruction in ID.
- ID_USES_RS1  in  1  ID instruction reads rs1.
- ID_USES_RS2  in  1  ID instruction reads rs2.
- EX_RD  in  5  destination register of the instruction in EX.
- EX_MEM_READ  in  1  instruction in EX is a load.
- EX_MULDIV  in  1  instruction in EX is an M-extension op.
- BRANCH_TAKEN  in  1  EX resolved a taken branch or jump.
- IMEM_BUSYWAIT  in  1  instruction memory not ready.
- DMEM_BUSYWAIT  in  1  data memory not ready.
- PC_HOLD  out  1  PC keeps its value.
- IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD  out  1 each  register keeps its value.
- IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH  out  1 each  register loads a bubble (REG_WRITE_EN=0, READ_WRITE=0, BRANCH_JUMP=0) at the next edge.
- MULDIV_BUSY  out  1  state is MULDIV.
- STALL_COUNT  out  32  cycles in which PC_HOLD was asserted.

Behaviour:
- State machine: RUN, MULDIV. State, counter CNT and STALL_COUNT are registered. HOLD and FLUSH outputs are combinational from state, CNT and inputs.
- Reset (synchronous):
  - Next state RUN, CNT=0, STALL_COUNT=0.
  - While RESET=1, all HOLD=0 and IF_ID_FLUSH=ID_EX_FLUSH=EX_MEM_FLUSH=1, so the pipeline fills with bubbles.
  - Reset in MULDIV aborts the operation.
- Priority, highest first: RESET, DMEM_BUSYWAIT, MULDIV state / MUL/DIV start, BRANCH_TAKEN, load-use, IMEM_BUSYWAIT. HOLD wins over FLUSH on the same register.
- DMEM_BUSYWAIT=1:
  - All five HOLDs=1, all FLUSHes=0.
  - State, CNT frozen.
  - STALL_COUNT increments.
- MUL/DIV start: state RUN and EX_MULDIV=1.
  - PC_HOLD, IF_ID_HOLD, ID_EX_HOLD=1; EX_MEM_FLUSH=1.
  - Next state MULDIV, CNT<=MULDIV_CYCLES-2.
- MULDIV state, CNT!=0: same holds and flush as MUL/DIV start; CNT decrements.
- MULDIV state, CNT==0: release cycle.
  - No holds.
  - Next state RUN.
  - EX_MULDIV is ignored, so there is no retrigger.
  - The instruction occupies EX exactly MULDIV_CYCLES cycles.
- BRANCH_TAKEN in RUN (not MUL/DIV start):
  - IF_ID_FLUSH=ID_EX_FLUSH=1, PC_HOLD=0 so the target loads.
  - Overrides load-use and IMEM_BUSYWAIT.
  - Ignored in MULDIV state.
- Load-use: EX_MEM_READ=1, EX_RD!=0, and (ID_USES_RS1 and ID_RS1==EX_RD, or ID_USES_RS2 and ID_RS2==EX_RD).
  - PC_HOLD=IF_ID_HOLD=1, ID_EX_FLUSH=1.
  - Exactly one bubble; forwarding covers the rest.
  - Overrides IMEM_BUSYWAIT, so IF/ID holds rather than flushes.
- IMEM_BUSYWAIT alone: PC_HOLD=1, IF_ID_FLUSH=1.
- STALL_COUNT: increments on every edge where PC_HOLD=1 and RESET=0; wraps at 2^32.
- Reading x0 (EX_RD=0) never produces a load-use stall.

Test Plan:
- Reset: hold RESET 2 cycles in MULDIV with CNT=10 -> state RUN, CNT=0, STALL_COUNT=0; during reset all FLUSH=1, all HOLD=0.
- Load-use: EX lw x5 (EX_MEM_READ=1, EX_RD=5), ID add x6,x5,x1 (ID_RS1=5) -> one cycle of PC_HOLD=IF_ID_HOLD=ID_EX_FLUSH=1. Repeat with EX_RD=0 -> no stall.
- MUL/DIV, MULDIV_CYCLES=4:
  - EX_MULDIV=1 in RUN -> holds for 3 consecutive cycles, release on the 4th, MULDIV_BUSY high for 3 cycles.
  - STALL_COUNT advances by 3.
- Branch with competing hazard: BRANCH_TAKEN=1 together with a load-use match and IMEM_BUSYWAIT=1 -> IF_ID_FLUSH=ID_EX_FLUSH=1, PC_HOLD=0.
- DMEM_BUSYWAIT mid-MULDIV: assert for 5 cycles at CNT=1 -> all HOLD=1, CNT stays 1. After deassert, one more hold cycle, then release.
- STALL_COUNT wrap: preload via 2^32-1 stall cycles (force) -> next stall gives 0.
